// File: rtl/sseg_pkg.sv
// Shared types and constants for the 7-segment display path (scanner and bin_to_sseg).
package sseg_pkg;

  localparam int SEG_W = 7;
  localparam int NIB_W = 4;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Inactive digit-select pattern: all ones when selects are active-low, else all zeros.
  function automatic logic [31:0] sel_off(input int n, input bit active_low);
    logic [31:0] r;
    r = '0;
    if (active_low) begin
      for (int i = 0; i < 32; i++) begin
        if (i < n) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sseg_digit_scan.sv
// Time-multiplexed N-digit 7-segment scanner: dead time then show per digit slot,
// frame-coherent shadow update and optional leading-zero blanking.
module sseg_digit_scan
  import sseg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int CLK_HZ         = 50_000_000,
  parameter int SLOT_HZ        = 4000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NIB_W*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]       dp_in,
  input  logic                      load,
  input  logic                      lz_en,
  output logic [NIB_W-1:0]          bin,
  output logic                      dp,
  output logic                      blank,
  output logic [N_DIGITS-1:0]       dig_sel,
  output state_t                    scan_state
);

  localparam int DIV   = CLK_HZ / SLOT_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0]    DEAD_END  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]    SHOW_END  = CNT_W'(DIV - BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_DIGITS - 1);
  localparam logic [31:0]         SEL_OFF_W = sel_off(N_DIGITS, SEL_ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] SEL_OFF   = SEL_OFF_W[N_DIGITS-1:0];

  if (!(BLANK_CYCLES > 0 && BLANK_CYCLES < DIV - 1)) begin : g_bad_blank
    $error("sseg_digit_scan: BLANK_CYCLES must satisfy 0 < BLANK_CYCLES < DIV-1");
  end

  state_t                    state, state_next;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic [IDX_W-1:0]          idx, idx_next;
  logic                      frame_wrap;

  logic [NIB_W*N_DIGITS-1:0] pend_v, shadow_v, shadow_v_next;
  logic [N_DIGITS-1:0]       pend_dp, shadow_dp, shadow_dp_next;
  logic                      pend_flag;
  logic                      copy;

  logic [N_DIGITS-1:0]       suppress_vec;
  logic                      upper_zero;
  logic                      sup;
  logic [N_DIGITS-1:0]       onehot;

  assign scan_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_DEAD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    idx_next   = idx;
    frame_wrap = 1'b0;
    case (state)
      ST_DEAD: begin
        if (cnt == DEAD_END) begin
          state_next = ST_SHOW;
          cnt_next   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_END) begin
          state_next = ST_DEAD;
          cnt_next   = '0;
          if (idx == LAST_IDX) begin
            idx_next   = '0;
            frame_wrap = 1'b1;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_DEAD;
        cnt_next   = '0;
      end
    endcase
  end

  // The shadow only changes at a frame boundary, so a frame never mixes two loads.
  always_comb begin
    copy           = frame_wrap && pend_flag;
    shadow_v_next  = copy ? pend_v  : shadow_v;
    shadow_dp_next = copy ? pend_dp : shadow_dp;
  end

  // A digit is a leading zero when it and every more-significant digit show 0 with no dp.
  always_comb begin
    upper_zero   = 1'b1;
    suppress_vec = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (shadow_v[i*NIB_W +: NIB_W] == '0) && !shadow_dp[i];
      if (i > 0) suppress_vec[i] = upper_zero;
    end
    sup    = lz_en && suppress_vec[idx];
    onehot = N_DIGITS'(1) << idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v    <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      shadow_v  <= '0;
      shadow_dp <= '0;
    end else begin
      shadow_v  <= shadow_v_next;
      shadow_dp <= shadow_dp_next;
      if (load) begin
        pend_v    <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end else if (copy) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // bin/dp move only on entry to DEAD, so they settle a full dead time before select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin     <= '0;
      dp      <= 1'b0;
      blank   <= 1'b1;
      dig_sel <= SEL_OFF;
    end else begin
      if (state == ST_DEAD && state_next == ST_SHOW) begin
        blank   <= sup;
        dig_sel <= sup ? SEL_OFF : (SEL_OFF ^ onehot);
      end else if (state == ST_SHOW && state_next == ST_DEAD) begin
        blank   <= 1'b1;
        dig_sel <= SEL_OFF;
        bin     <= shadow_v_next[idx_next*NIB_W +: NIB_W];
        dp      <= shadow_dp_next[idx_next];
      end
    end
  end

endmodule
